// File: rtl/orbit_framer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : orbit_framer_if                                          |
// | Purpose : buffer-read and serial/parallel output bundle of the     |
// |           orbit framer                                             |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
interface orbit_framer_if #(
    parameter int WORD_W = 12,
    parameter int ADDR_W = 11,
    parameter int FRM_W  = 7
);
    logic              iEn;
    logic [WORD_W-1:0] iWord;
    logic [ADDR_W-1:0] oAddr;
    logic              oRdEn;
    logic              oSwitch;
    logic              oOrbit;
    logic [WORD_W-1:0] oParallel;
    logic              oVal;
    logic [FRM_W-1:0]  oFrm;
    logic              oBusy;

    // Framer side
    modport master (
        input  iEn, iWord,
        output oAddr, oRdEn, oSwitch, oOrbit, oParallel, oVal, oFrm, oBusy
    );

    // Buffer / sink side
    modport slave (
        output iEn, iWord,
        input  oAddr, oRdEn, oSwitch, oOrbit, oParallel, oVal, oFrm, oBusy
    );
endinterface
`default_nettype wire

// File: rtl/orbit_framer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : orbit_framer                                             |
// | Purpose : serialises double-buffered telemetry words, MSB first,   |
// |           with phrase and frame-sync markers on the word MSB       |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module orbit_framer #(
    parameter int          WORD_W    = 12,
    parameter int          ADDR_W    = 11,
    parameter int          BIT_DIV   = 4,
    parameter logic [31:0] PHR_MARK  = 32'h4504_0154,
    parameter int          SYNC_WORD = 240,
    parameter int          FRM_N     = 128,
    parameter int          FRM_W     = (FRM_N > 1) ? $clog2(FRM_N) : 1
) (
    input  wire logic      iClkOrb,
    input  wire logic      reset,
    orbit_framer_if.master bus
);

    localparam int PH_W  = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int BIT_W = $clog2(WORD_W);

    localparam logic [PH_W-1:0]   c_phLast    = PH_W'(BIT_DIV - 1);
    localparam logic [PH_W-1:0]   c_primeLast = PH_W'(1);
    localparam logic [BIT_W-1:0]  c_bitLast   = BIT_W'(WORD_W - 1);
    localparam logic [BIT_W-1:0]  c_bitPen    = BIT_W'(WORD_W - 2);
    localparam logic [ADDR_W-1:0] c_idxLast   = '1;
    localparam logic [FRM_W-1:0]  c_frmLast   = FRM_W'(FRM_N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_SEND  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [PH_W-1:0]     r_phase;
    logic [BIT_W-1:0]    r_bit;
    logic [ADDR_W-1:0]   r_wordIdx;
    logic [ADDR_W-1:0]   r_addr;
    logic [FRM_W-1:0]    r_frm;
    logic                r_rdEn;
    logic                r_rdPend;
    logic [WORD_W-1:0]   r_latch;
    logic [WORD_W-2:0]   r_shift;
    logic [WORD_W-1:0]   r_par;
    logic                r_val;
    logic                r_orbit;
    logic                r_switch;

    logic                w_startPrime;
    logic                w_load;
    logic                w_endWord;
    logic                w_issueRd;
    logic                w_wrap;
    logic                w_mark;
    logic [4:0]          w_phrPos;
    logic [ADDR_W-1:0]   w_nextIdx;
    logic [FRM_W-1:0]    w_nextFrm;
    logic [WORD_W-1:0]   w_word;
    logic [WORD_W-1:0]   w_loadVal;

    always_ff @(posedge iClkOrb) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_startPrime = 1'b0;
        w_load       = 1'b0;
        w_endWord    = 1'b0;
        w_issueRd    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.iEn) begin
                    w_nextState  = S_PRIME;
                    w_startPrime = 1'b1;
                end
            end
            S_PRIME: begin
                if (r_phase == c_primeLast) begin
                    w_nextState = S_SEND;
                    w_load      = 1'b1;
                end
            end
            S_SEND: begin
                if (r_phase == c_phLast && r_bit == c_bitLast) begin
                    // enable only matters here; the word in flight always finishes
                    w_endWord = 1'b1;
                    if (bus.iEn) begin
                        w_load = 1'b1;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end
                if (r_phase == c_phLast && r_bit == c_bitPen) begin
                    w_issueRd = 1'b1;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        w_nextIdx = r_wordIdx;
        w_nextFrm = r_frm;
        w_wrap    = 1'b0;
        if (w_endWord) begin
            w_nextIdx = r_wordIdx + 1'b1;
            if (r_wordIdx == c_idxLast) begin
                w_wrap    = 1'b1;
                w_nextFrm = (r_frm == c_frmLast) ? '0 : r_frm + 1'b1;
            end
        end
        // markers belong to the word about to be loaded, i.e. the post-increment index
        w_phrPos  = 5'(w_nextIdx);
        w_mark    = PHR_MARK[w_phrPos] ||
                    ((w_nextFrm == '0) && (32'(w_nextIdx) == 32'(SYNC_WORD)));
        w_word    = r_rdPend ? bus.iWord : r_latch;
        w_loadVal = w_word;
        w_loadVal[WORD_W-1] = w_word[WORD_W-1] | w_mark;
    end

    always_ff @(posedge iClkOrb) begin
        if (reset) begin
            r_phase   <= '0;
            r_bit     <= '0;
            r_wordIdx <= '0;
            r_addr    <= '0;
            r_frm     <= '0;
            r_rdEn    <= 1'b0;
            r_rdPend  <= 1'b0;
            r_latch   <= '0;
            r_shift   <= '0;
            r_par     <= '0;
            r_val     <= 1'b0;
            r_orbit   <= 1'b0;
            r_switch  <= 1'b0;
        end else begin
            r_rdEn    <= w_startPrime | w_issueRd;
            r_rdPend  <= r_rdEn;
            r_val     <= w_load;
            r_wordIdx <= w_nextIdx;
            r_frm     <= w_nextFrm;
            if (w_startPrime) begin
                r_addr <= r_wordIdx;
            end else if (w_issueRd) begin
                r_addr <= r_wordIdx + 1'b1;
            end
            if (r_rdPend) begin
                r_latch <= bus.iWord;
            end
            if (w_wrap) begin
                r_switch <= ~r_switch;
            end

            if (w_load || w_startPrime || w_nextState == S_IDLE) begin
                r_phase <= '0;
                r_bit   <= '0;
            end else if (r_state == S_SEND && r_phase == c_phLast) begin
                r_phase <= '0;
                r_bit   <= r_bit + 1'b1;
            end else begin
                r_phase <= r_phase + 1'b1;
            end

            if (w_load) begin
                r_par   <= w_loadVal;
                r_shift <= w_loadVal[WORD_W-2:0];
                r_orbit <= w_loadVal[WORD_W-1];
            end else if (w_nextState == S_IDLE) begin
                r_orbit <= 1'b0;
            end else if (r_state == S_SEND && r_phase == c_phLast) begin
                r_orbit <= r_shift[WORD_W-2];
                r_shift <= {r_shift[WORD_W-3:0], 1'b0};
            end
        end
    end

    assign bus.oAddr     = r_addr;
    assign bus.oRdEn     = r_rdEn;
    assign bus.oSwitch   = r_switch;
    assign bus.oOrbit    = r_orbit;
    assign bus.oParallel = r_par;
    assign bus.oVal      = r_val;
    assign bus.oFrm      = r_frm;
    assign bus.oBusy     = (r_state != S_IDLE);

endmodule
`default_nettype wire
